// File: rtl/snax_csr_req_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snax_csr_req_buffer                                          |
// | Description : In-order CSR request queue with read-credit flow control and |
// |               a read-response queue. The optional same-cycle request       |
// |               bypass is enabled by SNAX_CSR_BUF_FALLTHROUGH_EN.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module snax_csr_req_buffer #(
  parameter int unsigned ReqDepth  = 4,
  parameter int unsigned RspDepth  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DataWidth-1:0]        up_req_data_i,
  input  logic [AddrWidth-1:0]        up_req_addr_i,
  input  logic                        up_req_write_i,
  input  logic                        up_req_valid_i,
  output logic                        up_req_ready_o,
  output logic [DataWidth-1:0]        up_rsp_data_o,
  output logic                        up_rsp_valid_o,
  input  logic                        up_rsp_ready_i,
  output logic [DataWidth-1:0]        dn_req_data_o,
  output logic [AddrWidth-1:0]        dn_req_addr_o,
  output logic                        dn_req_write_o,
  output logic                        dn_req_valid_o,
  input  logic                        dn_req_ready_i,
  input  logic [DataWidth-1:0]        dn_rsp_data_i,
  input  logic                        dn_rsp_valid_i,
  output logic                        dn_rsp_ready_o,
  output logic [$clog2(RspDepth):0]   outstanding_o,
  output logic                        idle_o
);

  localparam int unsigned ReqPtrW   = $clog2(ReqDepth);
  localparam int unsigned RspPtrW   = $clog2(RspDepth);
  localparam int unsigned ReqCntW   = ReqPtrW + 1;
  localparam int unsigned RspCntW   = RspPtrW + 1;
  localparam int unsigned ReqEntryW = 1 + AddrWidth + DataWidth;

  // Request storage: {write, addr, data}
  logic [ReqEntryW-1:0] req_mem_q [ReqDepth];
  logic [ReqPtrW-1:0]   req_wptr_q, req_rptr_q;
  logic [ReqCntW-1:0]   req_cnt_q, req_cnt_d;

  logic [DataWidth-1:0] rsp_mem_q [RspDepth];
  logic [RspPtrW-1:0]   rsp_wptr_q, rsp_rptr_q;
  logic [RspCntW-1:0]   rsp_cnt_q, rsp_cnt_d;

  logic [RspCntW-1:0]   outstanding_q, outstanding_d;

  logic req_empty, req_full, rsp_empty, rsp_full;
  logic req_push, req_pop, rsp_push, rsp_pop;
  logic up_req_fire, dn_req_fire, dn_rsp_fire;
  logic credit;
  logic [ReqEntryW-1:0] head;

  assign req_empty = (req_cnt_q == '0);
  assign req_full  = (req_cnt_q == ReqCntW'(ReqDepth));
  assign rsp_empty = (rsp_cnt_q == '0);
  assign rsp_full  = (rsp_cnt_q == RspCntW'(RspDepth));
  assign credit    = (outstanding_q < RspCntW'(RspDepth));
  assign head      = req_mem_q[req_rptr_q];

  assign up_req_ready_o = !req_full;
  assign up_req_fire    = up_req_valid_i && up_req_ready_o;
  assign dn_req_fire    = dn_req_valid_o && dn_req_ready_i;

  always_comb begin
    dn_req_write_o = head[ReqEntryW-1];
    dn_req_addr_o  = head[DataWidth +: AddrWidth];
    dn_req_data_o  = head[DataWidth-1:0];
    dn_req_valid_o = !req_empty && (head[ReqEntryW-1] || credit);
    req_push       = up_req_fire;
    req_pop        = dn_req_fire;
`ifdef SNAX_CSR_BUF_FALLTHROUGH_EN
    // Empty queue: present the incoming request directly; store it only if it stalls.
    if (req_empty && up_req_valid_i) begin
      dn_req_write_o = up_req_write_i;
      dn_req_addr_o  = up_req_addr_i;
      dn_req_data_o  = up_req_data_i;
      dn_req_valid_o = up_req_write_i || credit;
      req_push       = up_req_fire && !dn_req_fire;
      req_pop        = 1'b0;
    end
`endif
    req_cnt_d = req_cnt_q + ReqCntW'(req_push) - ReqCntW'(req_pop);
  end

  // Responses with nothing outstanding are stale and are swallowed.
  assign dn_rsp_ready_o = !rsp_full;
  assign dn_rsp_fire    = dn_rsp_valid_i && dn_rsp_ready_o;
  assign rsp_push       = dn_rsp_fire && (outstanding_q != '0);
  assign up_rsp_valid_o = !rsp_empty;
  assign up_rsp_data_o  = rsp_mem_q[rsp_rptr_q];
  assign rsp_pop        = up_rsp_valid_o && up_rsp_ready_i;

  always_comb begin
    rsp_cnt_d     = rsp_cnt_q + RspCntW'(rsp_push) - RspCntW'(rsp_pop);
    outstanding_d = outstanding_q;
    unique case ({dn_req_fire && !dn_req_write_o, rsp_pop})
      2'b10:   outstanding_d = outstanding_q + RspCntW'(1);
      2'b01:   outstanding_d = outstanding_q - RspCntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  assign outstanding_o = outstanding_q;
  assign idle_o        = req_empty && (outstanding_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ReqDepth); i++) req_mem_q[i] <= '0;
      req_wptr_q <= '0;
      req_rptr_q <= '0;
      req_cnt_q  <= '0;
    end else begin
      if (req_push) begin
        req_mem_q[req_wptr_q] <= {up_req_write_i, up_req_addr_i, up_req_data_i};
        req_wptr_q            <= req_wptr_q + ReqPtrW'(1);
      end
      if (req_pop) req_rptr_q <= req_rptr_q + ReqPtrW'(1);
      req_cnt_q <= req_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RspDepth); i++) rsp_mem_q[i] <= '0;
      rsp_wptr_q    <= '0;
      rsp_rptr_q    <= '0;
      rsp_cnt_q     <= '0;
      outstanding_q <= '0;
    end else begin
      if (rsp_push) begin
        rsp_mem_q[rsp_wptr_q] <= dn_rsp_data_i;
        rsp_wptr_q            <= rsp_wptr_q + RspPtrW'(1);
      end
      if (rsp_pop) rsp_rptr_q <= rsp_rptr_q + RspPtrW'(1);
      rsp_cnt_q     <= rsp_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snax_csr_req_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_snax_csr_req_buffer                                       |
// | Description : Directed scoreboard bench for snax_csr_req_buffer; honours   |
// |               SNAX_CSR_BUF_FALLTHROUGH_EN for request-latency expectations.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_snax_csr_req_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PD = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] up_req_data_i;
  logic [AW-1:0] up_req_addr_i;
  logic          up_req_write_i, up_req_valid_i, up_req_ready_o;
  logic [DW-1:0] up_rsp_data_o;
  logic          up_rsp_valid_o, up_rsp_ready_i;
  logic [DW-1:0] dn_req_data_o;
  logic [AW-1:0] dn_req_addr_o;
  logic          dn_req_write_o, dn_req_valid_o, dn_req_ready_i;
  logic [DW-1:0] dn_rsp_data_i;
  logic          dn_rsp_valid_i, dn_rsp_ready_o;
  logic [2:0]    outstanding_o;
  logic          idle_o;

  always #5 clk_i = ~clk_i;

  snax_csr_req_buffer #(.ReqDepth(4), .RspDepth(PD), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .up_req_data_i(up_req_data_i), .up_req_addr_i(up_req_addr_i),
    .up_req_write_i(up_req_write_i), .up_req_valid_i(up_req_valid_i),
    .up_req_ready_o(up_req_ready_o),
    .up_rsp_data_o(up_rsp_data_o), .up_rsp_valid_o(up_rsp_valid_o),
    .up_rsp_ready_i(up_rsp_ready_i),
    .dn_req_data_o(dn_req_data_o), .dn_req_addr_o(dn_req_addr_o),
    .dn_req_write_o(dn_req_write_o), .dn_req_valid_o(dn_req_valid_o),
    .dn_req_ready_i(dn_req_ready_i),
    .dn_rsp_data_i(dn_rsp_data_i), .dn_rsp_valid_i(dn_rsp_valid_i),
    .dn_rsp_ready_o(dn_rsp_ready_o),
    .outstanding_o(outstanding_o), .idle_o(idle_o)
  );

  typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} req_t;
  req_t          exp_dn_q[$];
  logic [DW-1:0] exp_rsp_q[$];
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] next_rd_data = 32'h0;
  logic          resp_en = 1'b0;
  int checks = 0, errors = 0;
  int dn_fire_cnt = 0, dn_rd_cnt = 0, up_rsp_cnt = 0;
  int base;
  req_t          mon_e;
  logic [DW-1:0] mon_d, dummy;
  logic          rsp_fire_s, rd_fire_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every downstream request and upstream response against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (dn_req_valid_o && dn_req_ready_i) begin
        dn_fire_cnt++;
        if (!dn_req_write_o) dn_rd_cnt++;
        if (exp_dn_q.size() == 0) check("dn_req_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = exp_dn_q.pop_front();
          check("dn_req_write", 64'(dn_req_write_o), 64'(mon_e.w));
          check("dn_req_addr", 64'(dn_req_addr_o), 64'(mon_e.a));
          check("dn_req_data", 64'(dn_req_data_o), 64'(mon_e.d));
        end
      end
      if (up_rsp_valid_o && up_rsp_ready_i) begin
        up_rsp_cnt++;
        if (exp_rsp_q.size() == 0) check("up_rsp_unexpected", 64'd1, 64'd0);
        else begin
          mon_d = exp_rsp_q.pop_front();
          check("up_rsp_data", 64'(up_rsp_data_o), 64'(mon_d));
        end
      end
      check("outstanding_bound", 64'(outstanding_o <= 3'(PD)), 64'd1);
    end
  end

  // Downstream CSR model: answers each read in order with an incrementing data value.
  always @(posedge clk_i) begin
    rsp_fire_s = dn_rsp_valid_i && dn_rsp_ready_o;
    rd_fire_s  = dn_req_valid_o && dn_req_ready_i && !dn_req_write_o && rst_ni;
    #1;
    if (rsp_fire_s && pend_q.size() > 0) dummy = pend_q.pop_front();
    if (rd_fire_s) begin
      pend_q.push_back(next_rd_data);
      next_rd_data = next_rd_data + 32'd1;
    end
    dn_rsp_valid_i = resp_en && (pend_q.size() > 0);
    dn_rsp_data_i  = (pend_q.size() > 0) ? pend_q[0] : '0;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    exp_dn_q.push_back({w, a, d});
    up_req_valid_i = 1'b1;
    up_req_write_i = w;
    up_req_addr_i  = a;
    up_req_data_i  = d;
    forever begin
      @(negedge clk_i);
      if (up_req_ready_o) break;
      n++;
      if (n > 60) begin
        check("push_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    up_req_valid_i = 1'b0;
    up_req_write_i = 1'b0;
    up_req_addr_i  = '0;
    up_req_data_i  = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(exp_dn_q.size() == 0 && exp_rsp_q.size() == 0 && idle_o && !up_rsp_valid_o) && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check(name, 64'(n < 100), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    up_req_valid_i = 0; up_req_write_i = 0; up_req_addr_i = '0; up_req_data_i = '0;
    up_rsp_ready_i = 0; dn_req_ready_i = 0; dn_rsp_valid_i = 0; dn_rsp_data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_up_req_ready", 64'(up_req_ready_o), 64'd1);
    check("rst_dn_req_valid", 64'(dn_req_valid_o), 64'd0);
    check("rst_up_rsp_valid", 64'(up_rsp_valid_o), 64'd0);
    check("rst_dn_rsp_ready", 64'(dn_rsp_ready_o), 64'd1);
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_dn_req_addr", 64'(dn_req_addr_o), 64'd0);
    check("rst_dn_req_data", 64'(dn_req_data_o), 64'd0);
    check("rst_up_rsp_data", 64'(up_rsp_data_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    wait_cycles(1);

    // Single write, 1-cycle latency
    dn_req_ready_i = 1'b1;
    push_req(1'b1, 32'h3C0, 32'hA5A5);
    @(negedge clk_i);
`ifdef SNAX_CSR_BUF_FALLTHROUGH_EN
    check("wr_valid_after_accept", 64'(dn_req_valid_o), 64'd0);
`else
    check("wr_valid_after_accept", 64'(dn_req_valid_o), 64'd1);
    check("wr_idle_busy", 64'(idle_o), 64'd0);
`endif
    wait_cycles(3);
    check("wr_idle_back", 64'(idle_o), 64'd1);
    check("wr_no_rsp", 64'(up_rsp_cnt), 64'd0);
    check("wr_dn_consumed", 64'(exp_dn_q.size()), 64'd0);

    // Request FIFO full with downstream stalled
    dn_req_ready_i = 1'b0;
    base = dn_fire_cnt;
    for (int i = 1; i <= 4; i++) push_req(1'b1, 32'h1000 + 32'(i), 32'(i));
    @(negedge clk_i);
    check("full_ready_low", 64'(up_req_ready_o), 64'd0);
    fork
      push_req(1'b1, 32'h1005, 32'd5);
      begin
        wait_cycles(3);
        check("full_still_blocked", 64'(up_req_ready_o), 64'd0);
        check("full_no_pop", 64'(dn_fire_cnt - base), 64'd0);
        dn_req_ready_i = 1'b1;
      end
    join
    wait_drain("full_drain");

    // Read credit limit: six reads, four credits
    resp_en = 1'b1;
    next_rd_data = 32'h10;
    up_rsp_ready_i = 1'b0;
    base = dn_rd_cnt;
    for (int i = 0; i < 6; i++) begin
      exp_rsp_q.push_back(32'h10 + 32'(i));
      push_req(1'b0, 32'h200 + 32'(4 * i), 32'h0);
    end
    wait_cycles(5);
    check("credit_outstanding", 64'(outstanding_o), 64'd4);
    check("credit_reads_issued", 64'(dn_rd_cnt - base), 64'd4);
    check("credit_stall_valid", 64'(dn_req_valid_o), 64'd0);
    check("credit_rsp_valid", 64'(up_rsp_valid_o), 64'd1);
    check("credit_rsp_head", 64'(up_rsp_data_o), 64'h10);
    check("credit_rsp_full", 64'(dn_rsp_ready_o), 64'd0);
    up_rsp_ready_i = 1'b1;
    wait_cycles(1);
    up_rsp_ready_i = 1'b0;
    wait_cycles(4);
    check("credit_read5_issued", 64'(dn_rd_cnt - base), 64'd5);
    check("credit_outstanding2", 64'(outstanding_o), 64'd4);
    up_rsp_ready_i = 1'b1;
    wait_drain("credit_drain");
    check("credit_all_reads", 64'(dn_rd_cnt - base), 64'd6);

    // Simultaneous read issue and response return
    up_rsp_ready_i = 1'b0;
    next_rd_data = 32'h20;
    for (int i = 0; i < 2; i++) begin
      exp_rsp_q.push_back(32'h20 + 32'(i));
      push_req(1'b0, 32'h300 + 32'(i), 32'h0);
    end
    wait_cycles(4);
    check("same_pre_outstanding", 64'(outstanding_o), 64'd2);
    dn_req_ready_i = 1'b0;
    exp_rsp_q.push_back(32'h22);
    push_req(1'b0, 32'h310, 32'h0);
    check("same_pending_valid", 64'(dn_req_valid_o), 64'd1);
    base = dn_rd_cnt;
    dn_req_ready_i = 1'b1;
    up_rsp_ready_i = 1'b1;
    wait_cycles(1);
    dn_req_ready_i = 1'b0;
    up_rsp_ready_i = 1'b0;
    check("same_read_fired", 64'(dn_rd_cnt - base), 64'd1);
    check("same_outstanding", 64'(outstanding_o), 64'd2);
    dn_req_ready_i = 1'b1;
    up_rsp_ready_i = 1'b1;
    wait_drain("same_drain");

    // Reset with reads outstanding, then a stale response
    up_rsp_ready_i = 1'b0;
    resp_en = 1'b0;
    push_req(1'b0, 32'h400, 32'h0);
    push_req(1'b0, 32'h404, 32'h0);
    wait_cycles(3);
    check("stale_pre_outstanding", 64'(outstanding_o), 64'd2);
    #2;
    rst_ni = 1'b0;
    pend_q.delete();
    exp_rsp_q.delete();
    exp_dn_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check("stale_rst_outstanding", 64'(outstanding_o), 64'd0);
    check("stale_rst_idle", 64'(idle_o), 64'd1);
    pend_q.push_back(32'hDEAD);
    resp_en = 1'b1;
    wait_cycles(1);
    check("stale_rsp_ready", 64'(dn_rsp_ready_o), 64'd1);
    wait_cycles(3);
    check("stale_consumed", 64'(pend_q.size()), 64'd0);
    check("stale_no_up_rsp", 64'(up_rsp_valid_o), 64'd0);
    check("stale_idle", 64'(idle_o), 64'd1);
    check("stale_outstanding", 64'(outstanding_o), 64'd0);

    // Request latency from an empty FIFO
    dn_req_ready_i = 1'b1;
    up_rsp_ready_i = 1'b1;
    exp_dn_q.push_back({1'b1, 32'h3FC, 32'hBEEF});
    up_req_valid_i = 1'b1; up_req_write_i = 1'b1;
    up_req_addr_i = 32'h3FC; up_req_data_i = 32'hBEEF;
    @(negedge clk_i);
`ifdef SNAX_CSR_BUF_FALLTHROUGH_EN
    check("lat_same_cycle", 64'(dn_req_valid_o), 64'd1);
    check("lat_same_addr", 64'(dn_req_addr_o), 64'h3FC);
`else
    check("lat_same_cycle", 64'(dn_req_valid_o), 64'd0);
`endif
    @(posedge clk_i); #1;
    up_req_valid_i = 1'b0; up_req_write_i = 1'b0;
    up_req_addr_i = '0; up_req_data_i = '0;
    @(negedge clk_i);
`ifdef SNAX_CSR_BUF_FALLTHROUGH_EN
    check("lat_next_cycle", 64'(dn_req_valid_o), 64'd0);
`else
    check("lat_next_cycle", 64'(dn_req_valid_o), 64'd1);
    check("lat_next_addr", 64'(dn_req_addr_o), 64'h3FC);
`endif
    wait_drain("lat_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
